// File: rtl/fifo_pop_ctrl.sv
// fifo_pop_ctrl: pops fifo_flops while a 2-entry output buffer has room and
// streams the captured words out on a valid/ready interface.
module fifo_pop_ctrl #(
    parameter int width    = 16,
    parameter int READ_LAT = 0,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             pndng,
    input  logic [width-1:0] fifo_dout,
    output logic             pop,
    output logic [width-1:0] m_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [CNT_W-1:0] word_cnt,
    output logic             busy
);
    logic [1:0]       occ;
    logic             inf;
    logic [width-1:0] buf0;
    logic [width-1:0] buf1;
    logic             deq;
    logic             wr;
    logic [1:0]       slot;
    logic [2:0]       committed;

    assign m_valid = (occ != 2'd0);
    assign m_data  = buf0;
    assign busy    = m_valid | inf;

    always_comb begin
        deq       = m_valid & m_ready;
        // words still owned once this edge's deq has left
        committed = {1'b0, occ} + {2'b0, inf} - {2'b0, deq};
        pop       = rst & en & pndng & (committed < 3'd2);
        wr        = (READ_LAT == 0) ? pop : inf;
        slot      = occ - {1'b0, deq};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            occ      <= '0;
            inf      <= 1'b0;
            buf0     <= '0;
            buf1     <= '0;
            word_cnt <= '0;
        end else begin
            inf <= (READ_LAT != 0) ? pop : 1'b0;
            occ <= occ + {1'b0, wr} - {1'b0, deq};
            if (deq) begin
                buf0     <= buf1;
                word_cnt <= word_cnt + CNT_W'(1);
            end
            // a write lands behind whatever survives the same-edge deq
            if (wr) begin
                if (slot == 2'd0) buf0 <= fifo_dout;
                else              buf1 <= fifo_dout;
            end
        end
    end
endmodule

// File: tb/tb_fifo_pop_ctrl.sv
// Bench for fifo_pop_ctrl: two instances (READ_LAT 0 and 1) fed by a queue-based
// FIFO model; a negedge monitor scores delivered words against push order.
`timescale 1ns/1ps
module tb_fifo_pop_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        en      [2];
    logic        pndng   [2];
    logic        pop     [2];
    logic        m_valid [2];
    logic        m_ready [2];
    logic        busy    [2];
    logic [15:0] dout    [2];
    logic [15:0] m_data  [2];
    logic [15:0] wc0;
    logic [3:0]  wc1;

    int checks = 0;
    int failures = 0;

    logic [15:0] fq [2][$];
    logic [15:0] exp_mem [2][256];
    int wr_ptr    [2] = '{0, 0};
    int pop_total [2] = '{0, 0};
    int consumed  [2] = '{0, 0};
    int dlv       [2] = '{0, 0};
    int cnt_m     [2] = '{0, 0};
    int pop_cyc   [2][256];
    int val_cyc   [2][256];
    logic        stall [2] = '{1'b0, 1'b0};
    logic [15:0] sdata [2];
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    fifo_pop_ctrl #(.width(16), .READ_LAT(0), .CNT_W(16)) u0 (
        .clk(clk), .rst(rst), .en(en[0]), .pndng(pndng[0]), .fifo_dout(dout[0]),
        .pop(pop[0]), .m_data(m_data[0]), .m_valid(m_valid[0]), .m_ready(m_ready[0]),
        .word_cnt(wc0), .busy(busy[0]));

    fifo_pop_ctrl #(.width(16), .READ_LAT(1), .CNT_W(4)) u1 (
        .clk(clk), .rst(rst), .en(en[1]), .pndng(pndng[1]), .fifo_dout(dout[1]),
        .pop(pop[1]), .m_data(m_data[1]), .m_valid(m_valid[1]), .m_ready(m_ready[1]),
        .word_cnt(wc1), .busy(busy[1]));

    a_pop0: assert property (@(posedge clk) !(pop[0] && !pndng[0]));
    a_pop1: assert property (@(posedge clk) !(pop[1] && !pndng[1]));

    task automatic check(string name, int d, int act, int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s dut%0d: got 0x%0h, expected 0x%0h", name, d, act, exp);
        end
    endtask

    function automatic int wc(int unsigned d);
        return (d == 0) ? int'(wc0) : int'(wc1);
    endfunction

    function automatic void refresh();
        for (int unsigned d = 0; d < 2; d++) pndng[d] = (fq[d].size() != 0);
        dout[0] = (fq[0].size() != 0) ? fq[0][0] : 16'h0;
    endfunction

    task automatic push(int unsigned d, logic [15:0] w);
        fq[d].push_back(w);
        exp_mem[d][wr_ptr[d]] = w;
        wr_ptr[d]++;
        refresh();
    endtask

    // One clock of the FIFO model: pop seen mid-cycle is applied just after the edge.
    task automatic tick();
        logic        p [2];
        int          nc;
        logic [15:0] w;
        @(negedge clk);
        p[0] = pop[0];
        p[1] = pop[1];
        nc = cyc;
        @(posedge clk);
        #1;
        for (int unsigned d = 0; d < 2; d++) begin
            if (p[d] && fq[d].size() != 0) begin
                pop_cyc[d][pop_total[d]] = nc;
                pop_total[d]++;
                w = fq[d].pop_front();
                if (d == 1) dout[1] = w;
            end
        end
        refresh();
    endtask

    task automatic do_reset();
        #2 rst = 1'b0;
        #0.5;
        for (int unsigned d = 0; d < 2; d++) begin
            check("rst_pop", d, int'(pop[d]), 0);
            check("rst_valid", d, int'(m_valid[d]), 0);
            check("rst_data", d, int'(m_data[d]), 0);
            check("rst_busy", d, int'(busy[d]), 0);
            check("rst_cnt", d, wc(d), 0);
        end
        #0.5 rst = 1'b1;
    endtask

    task automatic wait_dlv(int t0, int t1, int budget);
        int i = 0;
        while ((dlv[0] < t0 || dlv[1] < t1) && i < budget) begin
            tick();
            i++;
        end
        check("drain_in_budget", 0, int'(dlv[0] >= t0 && dlv[1] >= t1), 1);
    endtask

    // Monitor: scores every handshake against the pushed stream.
    always @(negedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned d = 0; d < 2; d++) begin
                consumed[d] = pop_total[d];
                cnt_m[d] = 0;
                stall[d] = 1'b0;
            end
        end else if (clk == 1'b0) begin
            for (int unsigned d = 0; d < 2; d++) begin
                check("busy", d, int'(busy[d]), int'(pop_total[d] != consumed[d]));
                check("pop_w_empty", d, int'(pop[d] && !pndng[d]), 0);
                check("word_cnt", d, wc(d), cnt_m[d] % ((d == 0) ? 65536 : 16));
                if (stall[d]) begin
                    check("hold_valid", d, int'(m_valid[d]), 1);
                    check("hold_data", d, int'(m_data[d]), int'(sdata[d]));
                end
                if (m_valid[d] && m_ready[d]) begin
                    if (consumed[d] >= pop_total[d]) begin
                        check("spurious_word", d, 1, 0);
                    end else begin
                        check("data", d, int'(m_data[d]), int'(exp_mem[d][consumed[d]]));
                        val_cyc[d][consumed[d]] = cyc;
                        consumed[d]++;
                        dlv[d]++;
                        cnt_m[d]++;
                    end
                end
                stall[d] = m_valid[d] && !m_ready[d];
                sdata[d] = m_data[d];
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int b[2];
        int db[2];
        int n;
        logic [15:0] w;
        for (int unsigned d = 0; d < 2; d++) begin
            en[d] = 1'b0;
            m_ready[d] = 1'b0;
            dout[d] = 16'h0;
        end
        refresh();
        repeat (3) tick();
        do_reset();

        // Streaming: 8 words, both latencies
        b[0] = pop_total[0];
        b[1] = pop_total[1];
        for (int unsigned i = 1; i <= 8; i++) begin
            push(0, 16'(i));
            push(1, 16'(i));
        end
        for (int unsigned d = 0; d < 2; d++) begin
            en[d] = 1'b1;
            m_ready[d] = 1'b1;
        end
        wait_dlv(dlv[0] + 8, dlv[1] + 8, 40);
        tick();
        for (int unsigned d = 0; d < 2; d++) begin
            check("first_latency", d, val_cyc[d][b[d]] - pop_cyc[d][b[d]], (d == 0) ? 1 : 2);
            check("pops_back2back", d, pop_cyc[d][b[d] + 7] - pop_cyc[d][b[d]], 7);
            check("words_back2back", d, val_cyc[d][b[d] + 7] - val_cyc[d][b[d]], 7);
            check("cnt_after8", d, wc(d), 8);
            check("idle_busy", d, int'(busy[d]), 0);
        end

        // Backpressure: 5 words, downstream stalled
        for (int unsigned d = 0; d < 2; d++) begin
            en[d] = 1'b0;
            m_ready[d] = 1'b0;
        end
        for (int unsigned i = 0; i < 5; i++) begin
            push(0, 16'h10 + 16'(i));
            push(1, 16'h10 + 16'(i));
        end
        b[0] = pop_total[0];
        b[1] = pop_total[1];
        en[0] = 1'b1;
        en[1] = 1'b1;
        repeat (10) tick();
        for (int unsigned d = 0; d < 2; d++) begin
            check("bp_pops", d, pop_total[d] - b[d], 2);
            check("bp_valid", d, int'(m_valid[d]), 1);
            check("bp_head", d, int'(m_data[d]), 16'h10);
            m_ready[d] = 1'b1;
        end
        wait_dlv(dlv[0] + 5, dlv[1] + 5, 40);
        check("bp_fifo_empty", 0, int'(pndng[0] | pndng[1]), 0);

        // en dropped after 3 pops
        en[0] = 1'b0;
        en[1] = 1'b0;
        for (int unsigned i = 0; i < 6; i++) begin
            push(0, 16'h20 + 16'(i));
            push(1, 16'h20 + 16'(i));
        end
        b[0] = pop_total[0];
        b[1] = pop_total[1];
        db[0] = dlv[0];
        db[1] = dlv[1];
        en[0] = 1'b1;
        en[1] = 1'b1;
        n = 0;
        while (pop_total[1] - b[1] < 3 && n < 20) begin
            tick();
            n++;
        end
        en[0] = 1'b0;
        en[1] = 1'b0;
        repeat (6) tick();
        for (int unsigned d = 0; d < 2; d++) begin
            check("en_off_pops", d, pop_total[d] - b[d], 3);
            check("en_off_words", d, dlv[d] - db[d], 3);
            check("en_off_busy", d, int'(busy[d]), 0);
            en[d] = 1'b1;
        end
        wait_dlv(db[0] + 6, db[1] + 6, 40);

        // Reset with buffer full / read in flight
        for (int unsigned d = 0; d < 2; d++) begin
            en[d] = 1'b0;
            m_ready[d] = 1'b0;
        end
        for (int unsigned i = 0; i < 4; i++) begin
            push(0, 16'h30 + 16'(i));
            push(1, 16'h30 + 16'(i));
        end
        en[0] = 1'b1;
        en[1] = 1'b1;
        repeat (4) tick();
        check("pre_rst_busy", 0, int'(busy[0] & busy[1]), 1);
        check("pre_rst_full", 0, int'(pop[0] | pop[1]), 0);
        do_reset();
        db[0] = dlv[0];
        db[1] = dlv[1];
        m_ready[0] = 1'b1;
        m_ready[1] = 1'b1;
        wait_dlv(db[0] + 2, db[1] + 2, 40);
        repeat (4) tick();
        check("post_rst_words", 0, dlv[0] - db[0], 2);
        check("post_rst_words", 1, dlv[1] - db[1], 2);

        // Randomised traffic, 18 words, CNT_W=4 wrap on dut1
        do_reset();
        db[0] = dlv[0];
        db[1] = dlv[1];
        n = 0;
        for (int unsigned i = 0; i < 3000 && (dlv[0] - db[0] < 18 || dlv[1] - db[1] < 18); i++) begin
            tick();
            for (int unsigned d = 0; d < 2; d++) begin
                en[d] = ($urandom_range(0, 3) != 0);
                m_ready[d] = ($urandom_range(0, 1) == 1);
            end
            if (n < 18 && $urandom_range(0, 1) == 1) begin
                w = 16'($urandom);
                push(0, w);
                push(1, w);
                n++;
            end
        end
        check("rand_done", 0, int'(dlv[0] - db[0] == 18 && dlv[1] - db[1] == 18), 1);
        check("wrap_cnt", 0, wc(0), 18);
        check("wrap_cnt", 1, wc(1), 2);

        m_ready[0] = 1'b1;
        m_ready[1] = 1'b1;
        repeat (3) tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
